uart_word_feeder: RTL

//  Upstream stage of the UART transmitter. Buffers 32-bit words (TRNG samples written by the PicoRV32 bus) in a FIFO.

---
 rtl/uart_word_feeder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/uart_word_feeder.sv
// Word FIFO in front of the UART transmitter. It sends one byte per frame and paces itself on tx_active/tx_done.
// Build option UART_FEED_HEX_EN: each word goes out as 8 uppercase hex digits plus CR LF instead of 4 raw bytes.
//
// state   | meaning
// S_IDLE  | no word in flight; pops the next word when the FIFO is not empty
// S_READY | word loaded; waits for the transmitter to be idle with its cleanup finished
// S_ACK   | strobe issued; waits for the transmitter to accept the frame
// S_DONE  | frame in progress; waits for tx_done
module uart_word_feeder #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [31:0]           wr_data,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow,
   input  logic                  clr_ovf,
   output logic                  data_valid,
   output logic [7:0]            tx_byte,
   input  logic                  tx_active,
   input  logic                  tx_done,
   output logic                  busy
);
   localparam int DEPTH = 2**DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);
`ifdef UART_FEED_HEX_EN
   localparam logic [3:0] LAST_IDX = 4'd9;
`else
   localparam logic [3:0] LAST_IDX = 4'd3;
`endif

   typedef enum logic [1:0] {S_IDLE, S_READY, S_ACK, S_DONE} state_t;

   state_t                 state, state_nxt;
   logic [31:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
   logic [31:0]            sh;
   logic [3:0]             byte_cnt;
   logic [7:0]             cur_byte;
   logic                   push, pop, fire, advance, last_byte;

   assign full      = (level == LEVEL_FULL);
   assign empty     = (level == '0);
   assign push      = wr_en && !full;
   assign last_byte = (byte_cnt == LAST_IDX);
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (!empty) state_nxt = S_READY;
         S_READY: if (!tx_active && !tx_done) state_nxt = S_ACK;
         S_ACK:   if (tx_active) state_nxt = S_DONE;
         S_DONE:  if (tx_done) state_nxt = last_byte ? S_IDLE : S_READY;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      pop     = (state == S_IDLE) && !empty;
      fire    = (state == S_READY) && !tx_active && !tx_done;
      advance = (state == S_DONE) && tx_done;
   end

`ifdef UART_FEED_HEX_EN
   logic [3:0] nib;
   always_comb begin
      nib = sh[{3'd7 - byte_cnt[2:0], 2'b00} +: 4];
      if (byte_cnt == 4'd8)      cur_byte = 8'h0D;
      else if (byte_cnt == 4'd9) cur_byte = 8'h0A;
      else if (nib < 4'd10)      cur_byte = 8'h30 + {4'h0, nib};
      else                       cur_byte = 8'h37 + {4'h0, nib};
   end
`else
   always_comb begin
      cur_byte = sh[{byte_cnt[1:0], 3'b000} +: 8];
   end
`endif

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   // A write into a full FIFO is always dropped and flagged, even if a pop frees a slot in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
         if (push && !pop)      level <= level + (DEPTH_LOG2+1)'(1);
         else if (pop && !push) level <= level - (DEPTH_LOG2+1)'(1);
         if (wr_en && full) overflow <= 1'b1;
         else if (clr_ovf)  overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh         <= '0;
         byte_cnt   <= '0;
         data_valid <= 1'b0;
         tx_byte    <= 8'h00;
      end else begin
         data_valid <= fire;
         if (pop) begin
            sh       <= mem[rd_ptr];
            byte_cnt <= '0;
         end else if (advance) begin
            byte_cnt <= byte_cnt + 4'd1;
         end
         if (fire) tx_byte <= cur_byte;
      end
   end
endmodule
